regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (RegWrite/WriteReg/WriteData) between two writeback sources.
  - Source 0: ALU/execute result.
  - Source 1: load-return data.
- Each source has a small FIFO with a valid/ready handshake. A round-robin arbiter pops one entry per cycle into a registered write-port stage.
- A pending-write bitmap is exported for the hazard/stall logic.

---
 rtl/regfile_wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two source FIFOs share one registered register-file write port.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [4:0]        s0_addr,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [4:0]        s1_addr,
    input  logic [DATA_W-1:0] s1_data,
    output logic              RegWrite,
    output logic [4:0]        WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              grant_src,
    output logic [31:0]       pending
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           fifo_mem [2][DEPTH];
    entry_t           in_entry [2];
    logic [PTR_W-1:0] wr_ptr   [2];
    logic [PTR_W-1:0] rd_ptr   [2];
    logic [CNT_W-1:0] count    [2];
    logic [CNT_W-1:0] count_nxt[2];
    logic             ready_q  [2];

    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       non_empty;
    logic             gnt_valid;
    logic             gnt_src_c;
    logic             last_grant;
    entry_t           head;
    logic [PTR_W-1:0] offset;

    assign in_entry[0] = {s0_addr, s0_data};
    assign in_entry[1] = {s1_addr, s1_data};
    assign s0_ready    = ready_q[0];
    assign s1_ready    = ready_q[1];
    assign push[0]     = s0_valid & ready_q[0];
    assign push[1]     = s1_valid & ready_q[1];

    // Round-robin grant on registered FIFO occupancy; ties go to the source not granted last.
    always_comb begin
        non_empty[0] = (count[0] != '0);
        non_empty[1] = (count[1] != '0);
        gnt_valid    = |non_empty;
        gnt_src_c    = (&non_empty) ? ~last_grant : non_empty[1];
        pop          = 2'b00;
        if (gnt_valid) begin
            pop[gnt_src_c] = 1'b1;
        end
        head = fifo_mem[gnt_src_c][rd_ptr[gnt_src_c]];
    end

    // Next occupancy per FIFO.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            count_nxt[k] = count[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k]) begin
                fifo_mem[k][wr_ptr[k]] <= in_entry[k];
            end
        end
    end

    // FIFO pointers, counts and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr[k]  <= '0;
                rd_ptr[k]  <= '0;
                count[k]   <= '0;
                ready_q[k] <= 1'b1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
                end
                count[k]   <= count_nxt[k];
                ready_q[k] <= (count_nxt[k] < CNT_W'(DEPTH));
            end
        end
    end

    // Last-grant pointer starts at 1 so source 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (gnt_valid) begin
            last_grant <= gnt_src_c;
        end
    end

    // Registered write port; writes to r0 are consumed but never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            grant_src <= 1'b0;
        end else if (gnt_valid) begin
            RegWrite  <= (head.addr != 5'd0);
            WriteReg  <= head.addr;
            WriteData <= head.data;
            grant_src <= gnt_src_c;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    // Pending bitmap over every queued entry of both FIFOs.
    always_comb begin
        pending = '0;
        offset  = '0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                offset = PTR_W'(i) - rd_ptr[k];
                if ({1'b0, offset} < count[k]) begin
                    pending[fifo_mem[k][i].addr] = 1'b1;
                end
            end
        end
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with per-source writeback scoreboards.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s0_valid, s1_valid;
    logic        s0_ready, s1_ready;
    logic [4:0]  s0_addr, s1_addr;
    logic [31:0] s0_data, s1_data;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        grant_src;
    logic [31:0] pending;

    regfile_wb_arbiter #(.DEPTH(2), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .grant_src(grant_src), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         q0[$];
    wr_t         q1[$];
    int          n_pass  = 0;
    int          n_total = 0;
    wr_t         src0[8];
    wr_t         src1[8];
    int          n0, n1, i0, i1;
    logic        obs_we  [32];
    logic [4:0]  obs_reg [32];
    logic [31:0] obs_data[32];
    logic        obs_gs  [32];
    logic        obs_r1  [32];
    logic [31:0] obs_pend[32];
    int          acc1_after[32];
    int          exp_seq[6] = '{1, 9, 2, 10, 3, 11};
    int          idle_writes;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: every enabled write must match the oldest expected entry of its source.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && RegWrite === 1'b1) begin
            if (grant_src === 1'b0) begin
                if (q0.size() == 0) check("sb_s0_unexpected", 64'(WriteReg), 64'h0);
                else check("sb_s0_write", 64'({WriteReg, WriteData}), 64'(q0.pop_front()));
            end else begin
                if (q1.size() == 0) check("sb_s1_unexpected", 64'(WriteReg), 64'h0);
                else check("sb_s1_write", 64'({WriteReg, WriteData}), 64'(q1.pop_front()));
            end
        end
    end

    task automatic tick(output bit a0, output bit a1);
        a0 = s0_valid && s0_ready;
        a1 = s1_valid && s1_ready;
        @(posedge clk);
        if (a0 && s0_addr != 5'd0) q0.push_back({s0_addr, s0_data});
        if (a1 && s1_addr != 5'd0) q1.push_back({s1_addr, s1_data});
        @(negedge clk);
    endtask

    task automatic run_stream(input int cycles);
        bit a0, a1;
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < cycles; c++) begin
            obs_we[c]   = RegWrite;
            obs_reg[c]  = WriteReg;
            obs_data[c] = WriteData;
            obs_gs[c]   = grant_src;
            obs_r1[c]   = s1_ready;
            obs_pend[c] = pending;
            s0_valid = (i0 < n0);
            s1_valid = (i1 < n1);
            if (i0 < n0) {s0_addr, s0_data} = src0[i0];
            if (i1 < n1) {s1_addr, s1_data} = src1[i1];
            tick(a0, a1);
            if (a0) i0++;
            if (a1) i1++;
            acc1_after[c] = i1;
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (8) @(negedge clk);
        check({tag, "_all_accepted"}, 64'(i0 + i1), 64'(n0 + n1));
        check({tag, "_sb_empty"}, 64'(q0.size() + q1.size()), 64'h0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        s0_addr  = '0;
        s1_addr  = '0;
        s0_data  = '0;
        s1_data  = '0;
        repeat (2) @(negedge clk);
        q0.delete();
        q1.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        do_reset();
        check("rst_regwrite", 64'(RegWrite), 64'h0);
        check("rst_writereg", 64'(WriteReg), 64'h0);
        check("rst_writedata", 64'(WriteData), 64'h0);
        check("rst_grant_src", 64'(grant_src), 64'h0);
        check("rst_pending", 64'(pending), 64'h0);
        check("rst_ready", 64'({s0_ready, s1_ready}), 64'h3);

        // Single write on an idle port.
        src0[0] = {5'd5, 32'hDEADBEEF};
        n0 = 1; n1 = 0;
        run_stream(5);
        check("single_pend_c0", 64'(obs_pend[0]), 64'h0);
        check("single_pend_c1", 64'(obs_pend[1]), 64'h20);
        check("single_pend_c2", 64'(obs_pend[2]), 64'h0);
        check("single_we_c1", 64'(obs_we[1]), 64'h0);
        check("single_we_c2", 64'(obs_we[2]), 64'h1);
        check("single_reg_c2", 64'(obs_reg[2]), 64'h5);
        check("single_data_c2", 64'(obs_data[2]), 64'hDEADBEEF);
        check("single_gs_c2", 64'(obs_gs[2]), 64'h0);
        check("single_we_c3", 64'(obs_we[3]), 64'h0);
        drain("single");

        // Contention: alternating grants, no bubbles.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            src0[k] = {5'(k + 1), $urandom};
            src1[k] = {5'(k + 9), $urandom};
        end
        n0 = 3; n1 = 3;
        run_stream(10);
        check("cont_we_c1", 64'(obs_we[1]), 64'h0);
        for (int k = 0; k < 6; k++) begin
            check("cont_we", 64'(obs_we[2 + k]), 64'h1);
            check("cont_seq", 64'(obs_reg[2 + k]), 64'(exp_seq[k]));
        end
        check("cont_we_c8", 64'(obs_we[8]), 64'h0);
        drain("cont");

        // Backpressure on source 1 while source 0 stays busy.
        do_reset();
        for (int k = 0; k < 4; k++) src0[k] = {5'(k + 20), $urandom};
        for (int k = 0; k < 3; k++) src1[k] = {5'(k + 12), $urandom};
        n0 = 4; n1 = 3;
        run_stream(14);
        check("bp_acc1_c1", 64'(acc1_after[1]), 64'h2);
        check("bp_ready1_c2", 64'(obs_r1[2]), 64'h0);
        check("bp_acc1_c2", 64'(acc1_after[2]), 64'h2);
        check("bp_ready1_c3", 64'(obs_r1[3]), 64'h1);
        check("bp_acc1_c3", 64'(acc1_after[3]), 64'h3);
        drain("bp");

        // Write to r0 is consumed silently; the next write follows.
        do_reset();
        src0[0] = {5'd0, 32'h00001234};
        src0[1] = {5'd7, 32'h00000077};
        n0 = 2; n1 = 0;
        run_stream(6);
        check("r0_pend_c1", 64'(obs_pend[1]), 64'h0);
        check("r0_we_c2", 64'(obs_we[2]), 64'h0);
        check("r0_reg_c2", 64'(obs_reg[2]), 64'h0);
        check("r0_data_c2", 64'(obs_data[2]), 64'h1234);
        check("r0_pend_c2", 64'(obs_pend[2]), 64'h80);
        check("r0_we_c3", 64'(obs_we[3]), 64'h1);
        check("r0_reg_c3", 64'(obs_reg[3]), 64'h7);
        check("r0_data_c3", 64'(obs_data[3]), 64'h77);
        drain("r0");

        // Reset while both FIFOs hold entries.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            src0[k] = {5'(k + 3), $urandom};
            src1[k] = {5'(k + 16), $urandom};
        end
        n0 = 4; n1 = 4;
        run_stream(3);
        check("mid_pend_busy", 64'(pending != 32'h0), 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_regwrite", 64'(RegWrite), 64'h0);
        check("mid_rst_pending", 64'(pending), 64'h0);
        repeat (2) @(negedge clk);
        q0.delete();
        q1.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_ready_after", 64'({s0_ready, s1_ready}), 64'h3);
        idle_writes = 0;
        repeat (6) begin
            if (RegWrite === 1'b1 || pending !== 32'h0) idle_writes++;
            @(negedge clk);
        end
        check("mid_no_stale", 64'(idle_writes), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
